// File: rtl/vga_console_pkg.sv
// ============================================================================
//  Module      : vga_console_pkg
//  Description : Shared geometry, state encoding and control-character codes
//                for the VGA text-console writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_console_pkg;

    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 30;
    localparam int ADDR_W   = 11;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

endpackage

`default_nettype wire

// File: rtl/vga_console_writer.sv
// ============================================================================
//  Module      : vga_console_writer
//  Description : Byte-stream to character-cell writer with cursor tracking,
//                line wrap and hardware line / screen clears into VRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_console_writer
    import vga_console_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        attr,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [15:0]       vram_wdata,
    output logic              vram_we,
    output logic [5:0]        cur_x,
    output logic [4:0]        cur_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

    // Constant-coefficient shift-and-add: only the set bits of COLS contribute.
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < 7; b++) begin
            if (((COLS >> b) & 1) == 1) begin
                acc = acc + (ADDR_W'(y) << b);
            end
        end
        return acc;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [5:0]        col_cnt_q, col_cnt_d;
    logic [5:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;

    logic [4:0]        next_y;
    logic              new_line;
    logic              printable;

    assign next_y    = (y_q == LAST_ROW) ? 5'd0 : y_q + 5'd1;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_cnt_d  = col_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        new_line   = 1'b0;

        case (state_q)
            CLR_ALL: begin
                we_d    = 1'b1;
                waddr_d = clr_addr_q;
                wdata_d = {attr, SPACE};
                if (clr_addr_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end

            CLR_LINE: begin
                we_d    = 1'b1;
                waddr_d = clr_addr_q;
                wdata_d = {attr, SPACE};
                if (col_cnt_q == LAST_COL) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                    col_cnt_d  = col_cnt_q + 6'd1;
                end
            end

            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        waddr_d = row_base(y_q) + ADDR_W'(x_q);
                        wdata_d = {attr, in_data};
                        if (x_q == LAST_COL) begin
                            new_line = 1'b1;
                        end else begin
                            x_d = x_q + 6'd1;
                        end
                    end else begin
                        case (in_data)
                            LF: new_line = 1'b1;
                            CR: x_d = 6'd0;
                            BS: if (x_q != 6'd0) x_d = x_q - 6'd1;
                            FF: begin
                                x_d        = 6'd0;
                                y_d        = 5'd0;
                                clr_addr_d = '0;
                                state_d    = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // Moving onto a new row always blanks it before more input.
                    if (new_line) begin
                        x_d        = 6'd0;
                        y_d        = next_y;
                        clr_addr_d = row_base(next_y);
                        col_cnt_d  = 6'd0;
                        state_d    = CLR_LINE;
                    end
                end
            end

            default: begin
                state_d    = CLR_ALL;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_ALL;
            clr_addr_q <= '0;
            col_cnt_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_cnt_q  <= col_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = ~in_ready;
    assign vram_we    = we_q;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
    assign cur_x      = x_q;
    assign cur_y      = y_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_console_writer.sv
// ============================================================================
//  Module      : tb_vga_console_writer
//  Description : Self-checking bench for vga_console_writer with a queue-based
//                behavioural model and directed plus randomised byte streams.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_console_writer;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  attr = 8'h0F;
    logic [10:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_we;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .attr       (attr),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit attr_noise = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: cursor + queue of pending clears
    int          m_x = 0, m_y = 0;
    int          clr_q[$];
    logic        e_we = 1'b0;
    logic [10:0] e_addr = '0;
    logic [15:0] e_data = '0;
    logic        e_ready = 1'b0;
    bit          m_init = 1'b0;

    task automatic push_row(input int row);
        for (int i = 0; i < COLS; i++) clr_q.push_back(row * COLS + i);
    endtask

    always @(posedge clk) begin
        m_init = 1'b1;
        e_we   = 1'b0;
        if (!rst_n) begin
            m_x = 0; m_y = 0;
            clr_q.delete();
            for (int i = 0; i < COLS * ROWS; i++) clr_q.push_back(i);
            e_addr = '0; e_data = '0;
        end else if (clr_q.size() > 0) begin
            e_we   = 1'b1;
            e_addr = 11'(clr_q.pop_front());
            e_data = {attr, 8'h20};
        end else if (in_valid) begin
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                e_we   = 1'b1;
                e_addr = 11'(m_y * COLS + m_x);
                e_data = {attr, in_data};
                m_x++;
                if (m_x == COLS) begin
                    m_x = 0; m_y = (m_y + 1) % ROWS; push_row(m_y);
                end
            end else if (in_data == 8'h0A) begin
                m_x = 0; m_y = (m_y + 1) % ROWS; push_row(m_y);
            end else if (in_data == 8'h0D) begin
                m_x = 0;
            end else if (in_data == 8'h08) begin
                if (m_x > 0) m_x--;
            end else if (in_data == 8'h0C) begin
                m_x = 0; m_y = 0;
                for (int i = 0; i < COLS * ROWS; i++) clr_q.push_back(i);
            end
        end
        e_ready = rst_n && (clr_q.size() == 0);
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cur_x", 32'(cur_x), 32'(m_x));
            check("cur_y", 32'(cur_y), 32'(m_y));
            check("in_ready", 32'(in_ready), 32'(e_ready));
            check("busy", 32'(busy), 32'(!e_ready));
            check("vram_we", 32'(vram_we), 32'(e_we));
            if (e_we) begin
                check("vram_waddr", 32'(vram_waddr), 32'(e_addr));
                check("vram_wdata", 32'(vram_wdata), 32'(e_data));
            end
        end
    end

    // ---------------- write log for the directed literal checks
    typedef struct { logic [10:0] a; logic [15:0] d; } wr_t;
    wr_t log_q[$];

    always @(posedge clk) begin
        #1;
        if (rst_n && vram_we) log_q.push_back('{vram_waddr, vram_wdata});
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready) begin
            if (n >= 5000) begin
                check("ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            if (attr_noise) attr = 8'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        if (attr_noise) attr = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_we", 32'(vram_we), 32'd0);
        check("rst_waddr", 32'(vram_waddr), 32'd0);
        check("rst_wdata", 32'(vram_wdata), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cur", 32'({cur_y, cur_x}), 32'd0);

        // Power-up clear
        #2 rst_n = 1'b1;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_clear_cycles", 32'(n), 32'd1200);
        check("init_clear_writes", 32'(log_q.size()), 32'd1200);
        check("init_first_addr", 32'(log_q[0].a), 32'd0);
        check("init_last_addr", 32'(log_q[1199].a), 32'd1199);
        check("init_last_data", 32'(log_q[1199].d), 32'h0F20);

        // "AB"
        log_q.delete();
        attr = 8'h1E;
        send("A");
        send("B");
        wait_ready();
        check("ab_count", 32'(log_q.size()), 32'd2);
        check("a_write", {5'd0, log_q[0].a, log_q[0].d}, {5'd0, 11'd0, 16'h1E41});
        check("b_write", {5'd0, log_q[1].a, log_q[1].d}, {5'd0, 11'd1, 16'h1E42});
        check("ab_cur_x", 32'(cur_x), 32'd2);

        // 41 x's with wrap
        send(8'h0D);
        wait_ready();
        log_q.delete();
        attr = 8'h07;
        for (int i = 0; i < 41; i++) send("x");
        check("wrap_count", 32'(log_q.size()), 32'd81);
        check("wrap_40th", {5'd0, log_q[39].a, log_q[39].d}, {5'd0, 11'd39, 16'h0778});
        check("wrap_clr_first", {5'd0, log_q[40].a, log_q[40].d}, {5'd0, 11'd40, 16'h0720});
        check("wrap_clr_last", 32'(log_q[79].a), 32'd79);
        check("wrap_41st", {5'd0, log_q[80].a, log_q[80].d}, {5'd0, 11'd40, 16'h0778});

        // FF mid-line
        send("q");
        wait_ready();
        log_q.delete();
        send(8'h0C);
        wait_ready();
        check("ff_writes", 32'(log_q.size()), 32'd1200);
        check("ff_last_addr", 32'(log_q[1199].a), 32'd1199);
        check("ff_cur", 32'({cur_y, cur_x}), 32'd0);

        // BS at x=0, CR at x=7
        log_q.delete();
        send(8'h08);
        repeat (2) @(negedge clk);
        check("bs_nowrite", 32'(log_q.size()), 32'd0);
        check("bs_cur_x", 32'(cur_x), 32'd0);
        for (int i = 0; i < 7; i++) send("k");
        check("k_cur_x", 32'(cur_x), 32'd7);
        log_q.delete();
        send(8'h0D);
        repeat (2) @(negedge clk);
        check("cr_nowrite", 32'(log_q.size()), 32'd0);
        check("cr_cur_x", 32'(cur_x), 32'd0);

        // Bottom-row LF wraps to the top row
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send("m");
        wait_ready();
        check("pos_5_29", 32'({cur_y, cur_x}), 32'({5'd29, 6'd5}));
        log_q.delete();
        send(8'h0A);
        check("lf_wrap_cur", 32'({cur_y, cur_x}), 32'd0);
        wait_ready();
        check("lf_clr_count", 32'(log_q.size()), 32'd40);
        check("lf_clr_first", 32'(log_q[0].a), 32'd0);
        check("lf_clr_last", 32'(log_q[39].a), 32'd39);

        // Reset in the middle of a full clear
        send(8'h0C);
        n = 0;
        while (!(vram_we && vram_waddr == 11'd600) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_600", 32'(vram_waddr), 32'd600);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(vram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        log_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_addr0", 32'(log_q[0].a), 32'd0);
        check("restart_addr1", 32'(log_q[1].a), 32'd1);

        // Randomised stream
        attr_noise = 1'b1;
        for (int i = 0; i < 600; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 1)       b = 8'h0C;
            else if (n < 6)  b = 8'h0A;
            else if (n < 10) b = 8'h0D;
            else if (n < 14) b = 8'h08;
            else if (n < 18) b = 8'($urandom);
            else             b = 8'($urandom_range(8'h20, 8'h7E));
            send(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_ready();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
